water_flow_monitor: RTL and testbench
=====================================

# water_flow_monitor

Supervises water movement for the washing machine controller. It takes the controller's fill/drain commands (`water_flow_mode`, `water_flow_reset`, `water_valve`, `drain_pump`) and the live `water_level_sensor`. It checks that the level keeps moving in the commanded direction. If the level stalls, it raises the `water_flow_error` input that the controller uses to pause and set its error LEDs. It sits between the actuator/sensor pins and the controller FSM.

## Interface
- `LEVEL_W`, 10: width of the water level sensor.
- `WINDOW_CYCLES`, 1000: consecutive non-progress active cycles before a fault is raised (≥2).
- `MIN_DELTA`, 4: minimum level change, in sensor LSBs, that counts as progress (≥1).
- `MAX_LEVEL`, 900: overfill threshold (used only with `WFM_OVERFILL_CHECK_EN`).
- `clk`  in  1  clock.
- `reset`  in  1  reset, asynchronous, active-high.
- `water_flow_reset`  in  1  synchronous clear from the controller; monitoring is suspended while high.
- `water_flow_mode`  in  1  1 = filling, 0 = draining. Sampled only when the matching actuator is on, so X elsewhere is tolerated.
- `water_valve`  in  1  fill valve command.
- `drain_pump`  in  1  drain pump command.
- `water_level_sensor`  in  LEVEL_W  current level.
- `water_flow_error`  out  1  registered fault flag; held until cleared.
- `error_code`  out  2  00 none, 01 fill stall, 10 drain stall, 11 overfill.
- `watching`  out  1  high in FILL_WATCH or DRAIN_WATCH.

## Operation
- Terms:
  - fill_act = !water_flow_reset & water_valve & water_flow_mode.
  - drain_act = !water_flow_reset & drain_pump & !water_flow_mode.
- States: IDLE, FILL_WATCH, DRAIN_WATCH, FAULT.
- Registers:
  - `baseline` (LEVEL_W).
  - `cnt`, clog2(WINDOW_CYCLES+1) bits.
- Priority:
  1. async `reset`.
  2. `water_flow_reset`=1: go to IDLE; clear cnt, baseline, error, code.
  3. State logic.
- IDLE:
  - fill_act → FILL_WATCH.
  - else drain_act → DRAIN_WATCH.
  - On either entry edge, baseline←level and cnt←0. The entry edge is not counted.
- FILL_WATCH:
  - Progress when level ≥ baseline+MIN_DELTA. The sum is computed in LEVEL_W+1 bits, with no wrap.
  - On progress: baseline←level, cnt←0.
  - Otherwise cnt←cnt+1. If cnt+1 = WINDOW_CYCLES, go to FAULT with code 01.
- DRAIN_WATCH:
  - Progress when baseline ≥ level+MIN_DELTA, or when level = 0. Zero counts as progress every cycle, so an empty drum never faults.
  - Otherwise count as above. Fault code is 10.
- In either watch state:
  - Neither fill_act nor drain_act: return to IDLE, cnt←0, no error.
  - The opposite activity becomes active: go directly to the other watch state with a fresh baseline and cnt←0.
- FAULT:
  - `water_flow_error`=1 and `error_code` held.
  - Actuator changes are ignored.
  - Exit only via `water_flow_reset` or `reset`.
- On a cycle where progress and window expiry coincide, progress wins.

## Timing
- Reset values: state IDLE, `water_flow_error`=0, `error_code`=00, `watching`=0, cnt=0, baseline=0.
- All outputs are registered. There is no combinational path from inputs to outputs.
- Fault latency: the error is visible after the edge that samples the WINDOW_CYCLES-th consecutive non-progress active cycle after the entry edge. That is WINDOW_CYCLES+1 edges after the first active cycle with a flat level.
- `water_flow_reset` clears the error at the next edge.
- Async `reset` mid-watch clears everything immediately. Monitoring restarts from IDLE.

## Configuration
- `WFM_OVERFILL_CHECK_EN` defined:
  - In FILL_WATCH, level > MAX_LEVEL → FAULT with code 11 at the next edge.
  - Overfill takes precedence over progress and stall on the same cycle.
- Not defined: no overfill check, code 11 is never produced, and `MAX_LEVEL` is unused.

## Test plan
- WINDOW=8, MIN_DELTA=4; fill_act with level stuck at 50 → error=1, code=01 exactly 9 edges after the first active edge, `watching`=0.
- Fill with level +4 every 5 cycles → no error over 200 cycles; `watching`=1 throughout.
- Drain from 100 falling 4 every 6 cycles down to 0, then held at 0 for 50 cycles → never faults. Drain stuck at 60 → code=10 after 9 edges.
- In FAULT, pulse `water_flow_reset` for 1 cycle → error=0, code=00, state IDLE. Valve dropping with no reset → error stays 1.
- Valve off after 5 stalled cycles, then back on → cnt restarts; the fault needs a full 9 more edges. Switch fill→drain mid-watch → fresh baseline, no error.
- With `WFM_OVERFILL_CHECK_EN`, MAX_LEVEL=900, level stepping to 901 during fill → code=11 next edge. Without the macro, no error.

Source files
------------

// File: rtl/water_flow_monitor.sv
// water_flow_monitor: flags stalled fill/drain water movement; optional overfill check enabled by WFM_OVERFILL_CHECK_EN
module water_flow_monitor #(
  parameter int LEVEL_W       = 10,
  parameter int WINDOW_CYCLES = 1000,
  parameter int MIN_DELTA     = 4,
  parameter int MAX_LEVEL     = 900
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               water_flow_reset,
  input  logic               water_flow_mode,
  input  logic               water_valve,
  input  logic               drain_pump,
  input  logic [LEVEL_W-1:0] water_level_sensor,
  output logic               water_flow_error,
  output logic [1:0]         error_code,
  output logic               watching
);
  localparam int CW = $clog2(WINDOW_CYCLES + 1);
  localparam logic [1:0] IDLE = 2'd0, FILL_WATCH = 2'd1, DRAIN_WATCH = 2'd2, FAULT = 2'd3;
`ifdef WFM_OVERFILL_CHECK_EN
  localparam bit OVF_EN = 1'b1;
`else
  localparam bit OVF_EN = 1'b0;
`endif
  localparam logic [LEVEL_W:0] DELTA = (LEVEL_W + 1)'(MIN_DELTA);
  localparam logic [CW-1:0]    LAST  = CW'(WINDOW_CYCLES);
  logic [1:0]         state, state_n, code_n;
  logic [LEVEL_W-1:0] baseline, baseline_n;
  logic [CW-1:0]      cnt, cnt_n, cnt_inc;
  logic               fill_act, drain_act, same_act, fill_prog, drain_prog, prog, overfill;
  assign fill_act   = !water_flow_reset && water_valve && water_flow_mode;
  assign drain_act  = !water_flow_reset && drain_pump && !water_flow_mode;
  assign same_act   = (state == FILL_WATCH) ? fill_act : drain_act;
  assign fill_prog  = {1'b0, water_level_sensor} >= ({1'b0, baseline} + DELTA);
  assign drain_prog = ({1'b0, baseline} >= ({1'b0, water_level_sensor} + DELTA)) || (water_level_sensor == '0);
  assign prog       = (state == FILL_WATCH) ? fill_prog : drain_prog;
  assign overfill   = OVF_EN && (state == FILL_WATCH) && (water_level_sensor > LEVEL_W'(MAX_LEVEL));
  assign cnt_inc    = cnt + CW'(1);
  // next-state: clear, (re)entry/idle, then progress vs stall counting in the watch states
  always_comb begin
    state_n    = state;
    baseline_n = baseline;
    cnt_n      = cnt;
    code_n     = error_code;
    if (water_flow_reset) begin
      state_n    = IDLE;
      baseline_n = '0;
      cnt_n      = '0;
      code_n     = 2'b00;
    end else if (state == IDLE || (state != FAULT && !same_act)) begin
      state_n    = fill_act ? FILL_WATCH : drain_act ? DRAIN_WATCH : IDLE;
      cnt_n      = '0;
      baseline_n = (fill_act || drain_act) ? water_level_sensor : baseline;
    end else if (state != FAULT) begin
      if (overfill) begin
        state_n = FAULT;
        code_n  = 2'b11;
      end else if (prog) begin
        baseline_n = water_level_sensor;
        cnt_n      = '0;
      end else begin
        cnt_n   = cnt_inc;
        state_n = (cnt_inc == LAST) ? FAULT : state;
        code_n  = (cnt_inc == LAST) ? ((state == FILL_WATCH) ? 2'b01 : 2'b10) : error_code;
      end
    end
  end
  // state and datapath registers, asynchronously cleared
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baseline   <= '0;
      cnt        <= '0;
      error_code <= 2'b00;
    end else begin
      state      <= state_n;
      baseline   <= baseline_n;
      cnt        <= cnt_n;
      error_code <= code_n;
    end
  end
  assign water_flow_error = (state == FAULT);
  assign watching         = (state == FILL_WATCH) || (state == DRAIN_WATCH);
endmodule

// File: tb/tb_water_flow_monitor.sv
// tb_water_flow_monitor: table vectors and hand sequences checked through an expected-result queue
module tb_water_flow_monitor;
  logic       clk = 1'b0, reset = 1'b1;
  logic       wfr = 1'b0, mode = 1'b0, valve = 1'b0, pump = 1'b0;
  logic [9:0] lvl = '0;
  logic       err, watch;
  logic [1:0] code;
  int checks = 0, errors = 0;

  typedef struct {
    logic wfr, valve, pump, mode;
    logic [9:0] lvl;
    logic e; logic [1:0] c; logic w;
  } vec_t;
  typedef struct { logic e; logic [1:0] c; logic w; string nm; } exp_t;
  exp_t sb[$];
  vec_t tbl[$];

  water_flow_monitor #(.LEVEL_W(10), .WINDOW_CYCLES(8), .MIN_DELTA(4), .MAX_LEVEL(900)) dut (
    .clk(clk), .reset(reset), .water_flow_reset(wfr), .water_flow_mode(mode),
    .water_valve(valve), .drain_pump(pump), .water_level_sensor(lvl),
    .water_flow_error(err), .error_code(code), .watching(watch)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(logic r, logic v, logic p, logic m, int l, logic e, logic [1:0] c, logic w);
    vec_t x;
    x.wfr = r; x.valve = v; x.pump = p; x.mode = m; x.lvl = 10'(l);
    x.e = e; x.c = c; x.w = w;
    return x;
  endfunction

  task automatic compare(input string nm);
    exp_t x;
    x = sb.pop_front();
    checks++;
    if (err !== x.e || code !== x.c || watch !== x.w) begin
      errors++;
      $display("FAIL %s: got err=%b code=%b watch=%b, want err=%b code=%b watch=%b",
               nm, err, code, watch, x.e, x.c, x.w);
    end
  endtask

  task automatic step(input vec_t v, input string nm);
    exp_t x;
    wfr = v.wfr; valve = v.valve; pump = v.pump; mode = v.mode; lvl = v.lvl;
    x.e = v.e; x.c = v.c; x.w = v.w; x.nm = nm;
    sb.push_back(x);
    @(posedge clk); #1;
    compare(nm);
  endtask

  task automatic expect_now(input logic e, input logic [1:0] c, input logic w, input string nm);
    exp_t x;
    x.e = e; x.c = c; x.w = w; x.nm = nm;
    sb.push_back(x);
    compare(nm);
  endtask

  initial begin
    // fill stuck at 50: fault exactly at the 9th edge
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 1, 0, 1, 50, i == 9, (i == 9) ? 2'b01 : 2'b00, i < 9));
    // FAULT ignores actuator changes
    tbl.push_back(mk(0, 0, 0, 1'bx, 50, 1, 2'b01, 0));
    tbl.push_back(mk(0, 0, 1, 0, 30, 1, 2'b01, 0));
    // single-cycle controller clear
    tbl.push_back(mk(1, 1, 0, 1, 50, 0, 2'b00, 0));
    tbl.push_back(mk(0, 0, 0, 1'bx, 50, 0, 2'b00, 0));
    // drain stuck at 60: code 10 at the 9th edge, then clear
    for (int i = 1; i <= 9; i++) tbl.push_back(mk(0, 0, 1, 0, 60, i == 9, (i == 9) ? 2'b10 : 2'b00, i < 9));
    tbl.push_back(mk(1, 0, 1, 0, 60, 0, 2'b00, 0));
    tbl.push_back(mk(0, 0, 0, 0, 60, 0, 2'b00, 0));

    #1;
    expect_now(0, 2'b00, 0, "reset_state");
    #3 reset = 1'b0;
    @(posedge clk); #1;
    expect_now(0, 2'b00, 0, "after_reset_idle");

    for (int i = 0; i < tbl.size(); i++) step(tbl[i], $sformatf("table_%0d", i));

    for (int i = 0; i < 200; i++) step(mk(0, 1, 0, 1, 100 + 4 * (i / 5), 0, 2'b00, 1), "fill_progress");
    step(mk(0, 0, 0, 1'bx, 256, 0, 2'b00, 0), "fill_stop_idle");

    for (int i = 0; i < 200; i++) begin
      int l;
      l = 100 - 4 * (i / 6);
      step(mk(0, 0, 1, 0, (l < 0) ? 0 : l, 0, 2'b00, 1), "drain_to_empty");
    end
    step(mk(0, 0, 0, 0, 0, 0, 2'b00, 0), "drain_stop_idle");

    for (int i = 0; i < 6; i++) step(mk(0, 1, 0, 1, 50, 0, 2'b00, 1), "pause_pre");
    step(mk(0, 0, 0, 1, 50, 0, 2'b00, 0), "pause_off");
    for (int i = 1; i <= 9; i++) step(mk(0, 1, 0, 1, 50, i == 9, (i == 9) ? 2'b01 : 2'b00, i < 9), "pause_restart");
    step(mk(1, 0, 0, 1, 50, 0, 2'b00, 0), "pause_clear");

    for (int i = 0; i < 7; i++) step(mk(0, 1, 0, 1, 200, 0, 2'b00, 1), "switch_fill");
    for (int i = 1; i <= 9; i++) step(mk(0, 0, 1, 0, 200, i == 9, (i == 9) ? 2'b10 : 2'b00, i < 9), "switch_drain");
    step(mk(1, 0, 0, 0, 200, 0, 2'b00, 0), "switch_clear");

    step(mk(0, 1, 0, 1, 890, 0, 2'b00, 1), "ovf_entry");
    step(mk(0, 1, 0, 1, 895, 0, 2'b00, 1), "ovf_895");
`ifdef WFM_OVERFILL_CHECK_EN
    step(mk(0, 1, 0, 1, 901, 1, 2'b11, 0), "ovf_901");
`else
    step(mk(0, 1, 0, 1, 901, 0, 2'b00, 1), "ovf_901");
`endif
    step(mk(1, 0, 0, 0, 901, 0, 2'b00, 0), "ovf_clear");

`ifndef WFM_OVERFILL_CHECK_EN
    step(mk(0, 1, 0, 1, 1021, 0, 2'b00, 1), "nowrap_entry");
    for (int i = 2; i <= 9; i++) step(mk(0, 1, 0, 1, 1023, i == 9, (i == 9) ? 2'b01 : 2'b00, i < 9), "nowrap_stall");
    step(mk(1, 0, 0, 0, 0, 0, 2'b00, 0), "nowrap_clear");
`endif

    for (int i = 0; i < 5; i++) step(mk(0, 1, 0, 1, 50, 0, 2'b00, 1), "async_pre");
    #2 reset = 1'b1;
    #1 expect_now(0, 2'b00, 0, "async_reset_mid");
    @(negedge clk) reset = 1'b0;
    for (int i = 1; i <= 9; i++) step(mk(0, 1, 0, 1, 50, i == 9, (i == 9) ? 2'b01 : 2'b00, i < 9), "async_restart");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
